// File: rtl/bitwise_rf_engine.sv
// bitwise_rf_engine: NREG x W register file driven by a small FSM with a tmp register.
// Supports MOV, XOR, AND, multi-cycle ASL, SWP and NOP; operands are latched at start.
// Optional feature macro: BITWISE_RF_ROL_EN enables opcode 101 as rotate-left (else NOP).
module bitwise_rf_engine #(
  parameter int W    = 8,
  parameter int NREG = 4,
  parameter int SHW  = 3,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s,
  input  logic [2+AW:0]   op,
  input  logic [W-1:0]    in,
  output logic [W-1:0]    out,
  output logic            done
);

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    MOV   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    WR    = 3'd4,
    SW1   = 3'd5,
    SW2   = 3'd6,
    NOP   = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b000;
  localparam logic [2:0] OPC_XOR = 3'b001;
  localparam logic [2:0] OPC_AND = 3'b010;
  localparam logic [2:0] OPC_ASL = 3'b011;
  localparam logic [2:0] OPC_SWP = 3'b100;
  localparam logic [2:0] OPC_ROL = 3'b101;

  state_t         state_q;
  logic [2:0]     opc_q;
  logic [AW-1:0]  ri_q;
  logic [W-1:0]   imm_q;
  logic [W-1:0]   tmp_q;
  logic [SHW-1:0] cnt_q;
  logic [W-1:0]   rf_q [NREG];
  logic           done_q;
  logic [W-1:0]   shift_d;

  assign out  = rf_q[0];
  assign done = done_q;

  // One-step shift of tmp: zero-fill left shift, or rotate when ROL is built in and latched
  always_comb begin
    shift_d = {tmp_q[W-2:0], 1'b0};
`ifdef BITWISE_RF_ROL_EN
    if (opc_q == OPC_ROL) begin
      shift_d = {tmp_q[W-2:0], tmp_q[W-1]};
    end
`endif
  end

  // Controller and datapath: state, latched operands, tmp/cnt and the register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT;
      opc_q   <= '0;
      ri_q    <= '0;
      imm_q   <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (s) begin
            opc_q  <= op[2+AW:AW];
            ri_q   <= op[AW-1:0];
            imm_q  <= in;
            done_q <= 1'b0;
            case (op[2+AW:AW])
              OPC_MOV: state_q <= MOV;
              OPC_XOR, OPC_AND, OPC_ASL, OPC_SWP: state_q <= LOAD;
`ifdef BITWISE_RF_ROL_EN
              OPC_ROL: state_q <= LOAD;
`else
              OPC_ROL: state_q <= NOP;
`endif
              default: state_q <= NOP;
            endcase
          end
        end
        MOV: begin
          rf_q[ri_q] <= imm_q;
          state_q    <= WAIT;
          done_q     <= 1'b1;
        end
        LOAD: begin
          case (opc_q)
            OPC_XOR, OPC_AND: begin
              tmp_q   <= rf_q[ri_q];
              state_q <= WR;
            end
            OPC_SWP: begin
              tmp_q   <= rf_q[0];
              state_q <= SW1;
            end
            default: begin
              tmp_q   <= rf_q[0];
              cnt_q   <= rf_q[ri_q][SHW-1:0];
              state_q <= (rf_q[ri_q][SHW-1:0] == '0) ? WR : SHIFT;
            end
          endcase
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            tmp_q <= shift_d;
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
              state_q <= WR;
            end
          end else begin
            state_q <= WR;
          end
        end
        WR: begin
          case (opc_q)
            OPC_XOR: rf_q[0] <= rf_q[0] ^ tmp_q;
            OPC_AND: rf_q[0] <= rf_q[0] & tmp_q;
            default: rf_q[0] <= tmp_q;
          endcase
          state_q <= WAIT;
          done_q  <= 1'b1;
        end
        SW1: begin
          rf_q[0] <= rf_q[ri_q];
          state_q <= SW2;
        end
        SW2: begin
          rf_q[ri_q] <= tmp_q;
          state_q    <= WAIT;
          done_q     <= 1'b1;
        end
        NOP: begin
          state_q <= WAIT;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= WAIT;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
